// File: rtl/mem_fill_arbiter.sv
// Arbitrates I-cache and D-cache miss fills onto one main-memory read port.
// Define FILL_ARB_RR_EN to alternate grants on simultaneous misses (default: D-cache wins).
module mem_fill_arbiter #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ICACHE_miss,
  input  logic [15:0]                    ICACHE_miss_addr,
  input  logic                           DCACHE_miss,
  input  logic [15:0]                    DCACHE_miss_addr,
  input  logic                           mem_data_valid,
  input  logic [15:0]                    mem_data_in,
  output logic                           mem_en,
  output logic [15:0]                    mem_addr,
  output logic [15:0]                    fill_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx,
  output logic                           ICACHE_fill_wen,
  output logic                           DCACHE_fill_wen,
  output logic                           ICACHE_fill_done,
  output logic                           DCACHE_fill_done,
  output logic                           ICACHE_busy,
  output logic                           DCACHE_busy
);
  localparam int IDX_W  = $clog2(BLOCK_WORDS);
  localparam int CNT_W  = IDX_W + 1;
  localparam int OFF_W  = IDX_W + 1;   // byte offset bits inside a block of 16-bit words
  localparam int BASE_W = 16 - OFF_W;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    issue_cnt_reg;
  logic [CNT_W-1:0]    recv_cnt_reg;
  logic [BASE_W-1:0]   base_reg;
  logic                gnt_i_reg;
  logic                gnt_d_reg;
  logic                mem_en_reg;
  logic [15:0]         mem_addr_reg;
  logic                i_done_reg;
  logic                d_done_reg;
  logic                take_i;
  logic                take_d;
  logic                fill_active;
  logic                unused_offset_bits;

`ifdef FILL_ARB_RR_EN
  logic                last_i_reg;
`endif

  assign unused_offset_bits = ^{ICACHE_miss_addr[OFF_W-1:0], DCACHE_miss_addr[OFF_W-1:0]};

  always_comb begin
    take_i = 1'b0;
    take_d = 1'b0;
`ifdef FILL_ARB_RR_EN
    if (ICACHE_miss && DCACHE_miss) begin
      take_d = last_i_reg;
      take_i = !last_i_reg;
    end else begin
      take_d = DCACHE_miss;
      take_i = ICACHE_miss;
    end
`else
    take_d = DCACHE_miss;
    take_i = ICACHE_miss && !DCACHE_miss;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      issue_cnt_reg <= '0;
      recv_cnt_reg  <= '0;
      base_reg      <= '0;
      gnt_i_reg     <= 1'b0;
      gnt_d_reg     <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      i_done_reg    <= 1'b0;
      d_done_reg    <= 1'b0;
`ifdef FILL_ARB_RR_EN
      last_i_reg    <= 1'b1;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          i_done_reg <= 1'b0;
          d_done_reg <= 1'b0;
          if (take_i || take_d) begin
            base_reg      <= take_d ? DCACHE_miss_addr[15:OFF_W] : ICACHE_miss_addr[15:OFF_W];
            gnt_i_reg     <= take_i;
            gnt_d_reg     <= take_d;
            issue_cnt_reg <= '0;
            recv_cnt_reg  <= '0;
            state_reg     <= FILL;
`ifdef FILL_ARB_RR_EN
            last_i_reg    <= take_i;
`endif
          end
        end
        FILL: begin
          if (issue_cnt_reg < CNT_W'(BLOCK_WORDS)) begin
            mem_en_reg    <= 1'b1;
            mem_addr_reg  <= {base_reg, issue_cnt_reg[IDX_W-1:0], 1'b0};
            issue_cnt_reg <= issue_cnt_reg + 1'b1;
          end else begin
            mem_en_reg   <= 1'b0;
            mem_addr_reg <= '0;
          end
          if (mem_data_valid) begin
            recv_cnt_reg <= recv_cnt_reg + 1'b1;
            // Last word of the block: stop any request and raise done for one cycle.
            if (recv_cnt_reg == CNT_W'(BLOCK_WORDS - 1)) begin
              state_reg    <= DONE;
              i_done_reg   <= gnt_i_reg;
              d_done_reg   <= gnt_d_reg;
              mem_en_reg   <= 1'b0;
              mem_addr_reg <= '0;
            end
          end
        end
        default: begin
          state_reg  <= IDLE;
          gnt_i_reg  <= 1'b0;
          gnt_d_reg  <= 1'b0;
          i_done_reg <= 1'b0;
          d_done_reg <= 1'b0;
        end
      endcase
    end
  end

  // Write path is combinational so each returning word lands in the cache the cycle it arrives.
  assign fill_active      = (state_reg == FILL) && mem_data_valid;
  assign ICACHE_fill_wen  = fill_active && gnt_i_reg;
  assign DCACHE_fill_wen  = fill_active && gnt_d_reg;
  assign fill_data        = fill_active ? mem_data_in : 16'h0000;
  assign fill_word_idx    = fill_active ? recv_cnt_reg[IDX_W-1:0] : '0;
  assign mem_en           = mem_en_reg;
  assign mem_addr         = mem_addr_reg;
  assign ICACHE_fill_done = i_done_reg;
  assign DCACHE_fill_done = d_done_reg;
  assign ICACHE_busy      = gnt_i_reg;
  assign DCACHE_busy      = gnt_d_reg;

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a 4-cycle fixed-latency memory model.
// Grant order on simultaneous misses follows FILL_ARB_RR_EN when that macro is defined.
module tb_mem_fill_arbiter;
  localparam int BW = 8;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ICACHE_miss = 1'b0;
  logic [15:0] ICACHE_miss_addr = 16'h0000;
  logic        DCACHE_miss = 1'b0;
  logic [15:0] DCACHE_miss_addr = 16'h0000;
  logic        mem_data_valid;
  logic [15:0] mem_data_in;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] fill_data;
  logic [2:0]  fill_word_idx;
  logic        ICACHE_fill_wen, DCACHE_fill_wen;
  logic        ICACHE_fill_done, DCACHE_fill_done;
  logic        ICACHE_busy, DCACHE_busy;

  logic        inj_v = 1'b0;
  logic [15:0] inj_d = 16'h0000;
  logic [LAT-1:0] pipe_v;
  logic [15:0] pipe_d [LAT];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_fill_arbiter #(.BLOCK_WORDS(BW)) dut (
    .clk(clk), .rst(rst),
    .ICACHE_miss(ICACHE_miss), .ICACHE_miss_addr(ICACHE_miss_addr),
    .DCACHE_miss(DCACHE_miss), .DCACHE_miss_addr(DCACHE_miss_addr),
    .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .fill_data(fill_data), .fill_word_idx(fill_word_idx),
    .ICACHE_fill_wen(ICACHE_fill_wen), .DCACHE_fill_wen(DCACHE_fill_wen),
    .ICACHE_fill_done(ICACHE_fill_done), .DCACHE_fill_done(DCACHE_fill_done),
    .ICACHE_busy(ICACHE_busy), .DCACHE_busy(DCACHE_busy)
  );

  // Memory returns (addr ^ 0xA5A5) LAT cycles after the request; shares the reset.
  always @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i < LAT; i++) pipe_d[i] <= 16'h0000;
    end else begin
      pipe_v    <= {pipe_v[LAT-2:0], mem_en};
      pipe_d[0] <= mem_addr ^ 16'hA5A5;
      for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign mem_data_valid = pipe_v[LAT-1] | inj_v;
  assign mem_data_in    = inj_v ? inj_d : pipe_d[LAT-1];

  function automatic logic [41:0] act_vec();
    return {mem_en, mem_addr, fill_data, fill_word_idx, ICACHE_fill_wen, DCACHE_fill_wen,
            ICACHE_fill_done, DCACHE_fill_done, ICACHE_busy, DCACHE_busy};
  endfunction

  // Expected outputs k cycles after the grant cycle (k=0 is the IDLE cycle that grants).
  function automatic logic [41:0] exp_vec(int k, bit is_d, logic [15:0] base, int done_k);
    logic en, wen, dn, bs;
    logic [15:0] a, d;
    logic [2:0] idx;
    int first_rx;
    first_rx = done_k - BW;
    en  = (k >= 2) && (k <= BW + 1);
    a   = en ? base + 16'(2 * (k - 2)) : 16'h0000;
    wen = (k >= first_rx) && (k <= done_k - 1);
    idx = wen ? 3'(k - first_rx) : 3'd0;
    d   = wen ? ((base + 16'(2 * (k - first_rx))) ^ 16'hA5A5) : 16'h0000;
    dn  = (k == done_k);
    bs  = (k >= 1) && (k <= done_k);
    return {en, a, d, idx, wen & !is_d, wen & is_d, dn & !is_d, dn & is_d, bs & !is_d, bs & is_d};
  endfunction

  task automatic chk(string name, int k, logic [41:0] act, logic [41:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, k, act, exp);
    end
  endtask

  task automatic drop_miss(bit is_d);
    if (is_d) DCACHE_miss = 1'b0;
    else      ICACHE_miss = 1'b0;
  endtask

  // Entered #1 after a posedge with the miss already driven; returns #1 after the edge ending done.
  task automatic fill_check(string name, bit is_d, logic [15:0] base, int done_k, int drop_k);
    for (int k = 0; k <= done_k; k++) begin
      @(negedge clk);
      chk(name, k, act_vec(), exp_vec(k, is_d, base, done_k));
      @(posedge clk);
      #1;
      if (k == drop_k || k == done_k) drop_miss(is_d);
    end
    $display("fill %s cache=%s base=%h checked", name, is_d ? "D" : "I", base);
  endtask

  task automatic idle_check(string name, int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk(name, k, act_vec(), 42'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic single_fill(string name, bit is_d, logic [15:0] addr, logic [15:0] base, int done_k, int drop_k);
    if (is_d) begin DCACHE_miss = 1'b1; DCACHE_miss_addr = addr; end
    else      begin ICACHE_miss = 1'b1; ICACHE_miss_addr = addr; end
    fill_check(name, is_d, base, done_k, drop_k);
  endtask

  task automatic pair_fill(string name, bit first_d);
    ICACHE_miss = 1'b1; ICACHE_miss_addr = 16'h4446;
    DCACHE_miss = 1'b1; DCACHE_miss_addr = 16'h888A;
    fill_check({name, "_1st"}, first_d, first_d ? 16'h8880 : 16'h4440, 14, 14);
    fill_check({name, "_2nd"}, !first_d, first_d ? 16'h4440 : 16'h8880, 14, 14);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ICACHE_miss = 1'b0;
    DCACHE_miss = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    string       name;
    bit          is_d;
    logic [15:0] addr;
    logic [15:0] exp_base;
    int          exp_done;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{name: "i_1236", is_d: 1'b0, addr: 16'h1236, exp_base: 16'h1230, exp_done: 14};
    vecs[1] = '{name: "d_abcf", is_d: 1'b1, addr: 16'hABCF, exp_base: 16'hABC0, exp_done: 14};
    vecs[2] = '{name: "i_ffff", is_d: 1'b0, addr: 16'hFFFF, exp_base: 16'hFFF0, exp_done: 14};
    vecs[3] = '{name: "d_0000", is_d: 1'b1, addr: 16'h0000, exp_base: 16'h0000, exp_done: 14};

    @(posedge clk);
    @(negedge clk);
    chk("reset_state", 0, act_vec(), 42'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_check("post_reset_idle", 2);

    for (int v = 0; v < 4; v++) begin
      single_fill(vecs[v].name, vecs[v].is_d, vecs[v].addr, vecs[v].exp_base, vecs[v].exp_done, vecs[v].exp_done);
      idle_check({vecs[v].name, "_idle"}, 1);
    end

    // Simultaneous misses from reset: D first, then alternate / fixed order.
    do_reset();
    pair_fill("pair_a", 1'b1);
    idle_check("pair_a_idle", 1);
    pair_fill("pair_b", 1'b1);
    idle_check("pair_b_idle", 1);
    single_fill("d_alone", 1'b1, 16'h2222, 16'h2220, 14, 14);
`ifdef FILL_ARB_RR_EN
    pair_fill("pair_c", 1'b0);
`else
    pair_fill("pair_c", 1'b1);
`endif
    idle_check("pair_c_idle", 1);

    // Reset after the third returned word of a D fill abandons it without done.
    DCACHE_miss = 1'b1;
    DCACHE_miss_addr = 16'h5550;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      chk("rst_mid_fill", k, act_vec(), exp_vec(k, 1'b1, 16'h5550, 14));
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    DCACHE_miss = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_check("after_rst_quiet", 8);
    single_fill("d_after_rst", 1'b1, 16'h5550, 16'h5550, 14, 14);
    idle_check("d_after_rst_idle", 1);

    // Stray valid in IDLE must not write nor advance the receive counter.
    inj_v = 1'b1;
    inj_d = 16'hBEEF;
    @(negedge clk);
    chk("idle_valid_ignored", 0, act_vec(), 42'd0);
    @(posedge clk);
    #1;
    inj_v = 1'b0;
    single_fill("i_after_stray", 1'b0, 16'h7770, 16'h7770, 14, 14);

    // Miss dropped after two words still completes the block.
    single_fill("d_drop", 1'b1, 16'h3334, 16'h3330, 14, 7);
    idle_check("d_drop_idle", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
